// File: rtl/mole_pkg.sv
// Shared definitions for the mole game autoplayer and the game-side blocks.
package mole_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUALIFY = 3'd1,
      ST_REACT   = 3'd2,
      ST_PRESS   = 3'd3,
      ST_CONFIRM = 3'd4,
      ST_OVER    = 3'd5,
      ST_RESTART = 3'd6
   } mole_state_t;

   localparam int DEF_REACT_CYCLES    = 3;
   localparam int DEF_HOLD_CYCLES     = 6;
   localparam int DEF_CONFIRM_TIMEOUT = 64;
   localparam int DEF_RESTART_GAP     = 16;

   localparam int         TMR_W       = 16;
   localparam logic [7:0] RESTART_BTN = 8'h01;

   // Saturating increment for the hit/miss counters.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/seg_prompt_decoder.sv
// Decodes the game's active-low 7-segment drive into a one-hot prompt index.
module seg_prompt_decoder (
   input  logic [6:0] seg_in,
   input  logic       dp_in,
   output logic       valid,
   output logic [2:0] k
);

   logic [2:0] zeros;

   // Count lit (low) segments and remember the index of the lit one.
   always_comb begin
      zeros = 3'd0;
      k     = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (!seg_in[i]) begin
            zeros = zeros + 3'd1;
            k     = 3'(i);
         end
      end
      valid = dp_in && (zeros == 3'd1);
   end

endmodule

// File: rtl/mole_autoplayer.sv
// Watches the game's display, presses the prompted button and tallies outcomes.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for a prompt, or for game over
//   QUALIFY    | prompt seen once, must repeat unchanged for one more cycle
//   REACT      | reaction delay before pressing
//   PRESS      | driving the target button
//   CONFIRM    | waiting for the score to move (hit) or the timeout (miss)
//   OVER       | game over seen, gap before the restart press
//   RESTART    | pressing button 0, then waiting for the game to resume
module mole_autoplayer
   import mole_pkg::*;
#(
   parameter int REACT_CYCLES    = DEF_REACT_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int CONFIRM_TIMEOUT = DEF_CONFIRM_TIMEOUT,
   parameter int RESTART_GAP     = DEF_RESTART_GAP
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [6:0] seg_in,
   input  logic       dp_in,
   input  logic [7:0] score_in,
   output logic [7:0] btn_out,
   output logic [7:0] hits,
   output logic [7:0] misses,
   output logic       busy
);

   mole_state_t      state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [2:0]       k_q, k_nxt;
   logic [7:0]       snap, snap_nxt;
   logic [7:0]       btn_nxt, hits_nxt, misses_nxt;
   logic             released, released_nxt;
   logic             p_valid;
   logic [2:0]       p_k;

   seg_prompt_decoder u_dec (
      .seg_in (seg_in),
      .dp_in  (dp_in),
      .valid  (p_valid),
      .k      (p_k)
   );

   assign busy = (state != ST_IDLE);

   // Register the state and every output so btn_out never sees an input path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         timer    <= '0;
         k_q      <= 3'd0;
         snap     <= 8'h00;
         btn_out  <= 8'h00;
         hits     <= 8'h00;
         misses   <= 8'h00;
         released <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         k_q      <= k_nxt;
         snap     <= snap_nxt;
         btn_out  <= btn_nxt;
         hits     <= hits_nxt;
         misses   <= misses_nxt;
         released <= released_nxt;
      end
   end

   // Next-state and next-output decision; btn_nxt reflects the state being entered.
   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      k_nxt        = k_q;
      snap_nxt     = snap;
      btn_nxt      = 8'h00;
      hits_nxt     = hits;
      misses_nxt   = misses;
      released_nxt = released;

      if (!enable) begin
         state_nxt = ST_IDLE;
         timer_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!dp_in) begin
                  state_nxt = ST_OVER;
                  timer_nxt = TMR_W'(RESTART_GAP - 1);
               end else if (p_valid) begin
                  k_nxt     = p_k;
                  state_nxt = ST_QUALIFY;
               end
            end
            ST_QUALIFY: begin
               if (p_valid && (p_k == k_q)) begin
                  state_nxt = ST_REACT;
                  timer_nxt = TMR_W'(REACT_CYCLES - 1);
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_REACT: begin
               if (!dp_in) begin
                  state_nxt = ST_OVER;
                  timer_nxt = TMR_W'(RESTART_GAP - 1);
               end else if (timer == '0) begin
                  state_nxt = ST_PRESS;
                  timer_nxt = TMR_W'(HOLD_CYCLES - 1);
                  snap_nxt  = score_in;
                  btn_nxt   = 8'h01 << k_q;
               end else begin
                  timer_nxt = timer - TMR_W'(1);
               end
            end
            ST_PRESS: begin
               if (!dp_in) begin
                  state_nxt = ST_OVER;
                  timer_nxt = TMR_W'(RESTART_GAP - 1);
               end else if (timer == '0) begin
                  state_nxt = ST_CONFIRM;
                  timer_nxt = TMR_W'(CONFIRM_TIMEOUT - 1);
               end else begin
                  timer_nxt = timer - TMR_W'(1);
                  btn_nxt   = 8'h01 << k_q;
               end
            end
            ST_CONFIRM: begin
               if (!dp_in) begin
                  state_nxt = ST_OVER;
                  timer_nxt = TMR_W'(RESTART_GAP - 1);
               end else if (score_in != snap) begin
                  hits_nxt  = sat_inc(hits);
                  state_nxt = ST_IDLE;
               end else if (timer == '0) begin
                  misses_nxt = sat_inc(misses);
                  state_nxt  = ST_IDLE;
               end else begin
                  timer_nxt = timer - TMR_W'(1);
               end
            end
            ST_OVER: begin
               if (timer == '0) begin
                  state_nxt    = ST_RESTART;
                  timer_nxt    = TMR_W'(HOLD_CYCLES - 1);
                  btn_nxt      = RESTART_BTN;
                  hits_nxt     = 8'h00;
                  misses_nxt   = 8'h00;
                  released_nxt = 1'b0;
               end else begin
                  timer_nxt = timer - TMR_W'(1);
               end
            end
            ST_RESTART: begin
               if (!released) begin
                  if (timer == '0) begin
                     released_nxt = 1'b1;
                  end else begin
                     timer_nxt = timer - TMR_W'(1);
                     btn_nxt   = RESTART_BTN;
                  end
               end else if (dp_in) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_autoplayer.sv
// Self-checking bench: timeline model of prompt/press/confirm episodes.
module tb_mole_autoplayer;

   localparam int R = 3;
   localparam int H = 6;
   localparam int C = 64;
   localparam int G = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [6:0] seg_in;
   logic       dp_in;
   logic [7:0] score_in;
   logic [7:0] btn_out;
   logic [7:0] hits;
   logic [7:0] misses;
   logic       busy;

   int n_chk = 0;
   int n_err = 0;
   int m_hits = 0;
   int m_misses = 0;

   mole_autoplayer #(
      .REACT_CYCLES    (R),
      .HOLD_CYCLES     (H),
      .CONFIRM_TIMEOUT (C),
      .RESTART_GAP     (G)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .seg_in   (seg_in),
      .dp_in    (dp_in),
      .score_in (score_in),
      .btn_out  (btn_out),
      .hits     (hits),
      .misses   (misses),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counters();
      chk("hits", 32'(hits), 32'(m_hits));
      chk("misses", 32'(misses), 32'(m_misses));
   endtask

   // One prompt episode. Edge n=0 is the first edge that sees the prompt.
   // Press spans edges R+1..R+H; confirm decisions at edges R+H+2..R+H+C+1.
   task automatic episode(input int k, input bit chg, input int nc, input int delta, input bit drop);
      int hit_n, end_n, dn, last;
      bit hit;
      logic [7:0] kb, eb;
      hit   = 1'b0;
      hit_n = 0;
      if (chg) begin
         hit_n = (nc + 1 > R + H + 2) ? nc + 1 : R + H + 2;
         hit   = (hit_n <= R + H + C + 1);
      end
      end_n = hit ? hit_n : R + H + C + 1;
      dn    = drop ? int'($urandom_range(0, end_n - 1)) : end_n;
      last  = drop ? dn + 1 : end_n;
      kb    = 8'h01 << k;
      seg_in = ~(7'h01 << k);
      for (int n = 0; n <= last; n++) begin
         step();
         eb = (n >= R + 1 && n <= R + H && n <= dn) ? kb : 8'h00;
         chk("btn_out", 32'(btn_out), 32'(eb));
         chk("busy", 32'(busy), 32'(n <= dn && n < end_n));
         if (n == R + 1) seg_in = 7'h7F;
         if (chg && n == nc) score_in = score_in + 8'(delta);
         if (drop && n == dn) begin
            enable = 1'b0;
            seg_in = 7'h7F;
         end
      end
      enable = 1'b1;
      if (!drop) begin
         if (hit) begin
            if (m_hits < 255) m_hits++;
         end else begin
            if (m_misses < 255) m_misses++;
         end
      end
      chk_counters();
      step();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [6:0] nz;
      rst_n    = 1'b0;
      enable   = 1'b0;
      seg_in   = 7'h7F;
      dp_in    = 1'b1;
      score_in = 8'd3;
      step();
      step();
      chk("rst_btn", 32'(btn_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk_counters();
      rst_n  = 1'b1;
      enable = 1'b1;
      step();
      chk("idle_busy", 32'(busy), 32'h0);

      // Prompt on segment 2, score 3->4 two cycles after release.
      episode(2, 1'b1, R + H + 3, 1, 1'b0);
      // Same prompt, score held: miss 64 cycles after release.
      episode(2, 1'b0, 0, 0, 1'b0);

      // Two lit segments, then alternating one-hot prompts: never pressed.
      seg_in = 7'b1110011;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("multi_btn", 32'(btn_out), 32'h0);
      end
      for (int i = 0; i < 12; i++) begin
         seg_in = (i % 2 == 0) ? 7'b1111110 : 7'b1111101;
         step();
         chk("flip_btn", 32'(btn_out), 32'h0);
      end
      seg_in = 7'h7F;
      step();
      step();
      chk("flip_busy", 32'(busy), 32'h0);
      chk_counters();

      // Game over during the third press cycle, then restart.
      seg_in = ~(7'h01 << 5);
      for (int n = 0; n <= R + 3; n++) begin
         step();
         chk("go_btn", 32'(btn_out), 32'((n >= R + 1) ? 8'h20 : 8'h00));
         if (n == R + 1) seg_in = 7'h7F;
      end
      dp_in = 1'b0;
      step();
      chk("go_release", 32'(btn_out), 32'h0);
      chk("go_busy", 32'(busy), 32'h1);
      chk_counters();
      for (int j = 1; j < G; j++) begin
         step();
         chk("over_btn", 32'(btn_out), 32'h0);
      end
      chk_counters();
      m_hits   = 0;
      m_misses = 0;
      for (int j = 0; j < H; j++) begin
         step();
         chk("restart_btn", 32'(btn_out), 32'h01);
         chk_counters();
      end
      for (int j = 0; j < 3; j++) begin
         step();
         chk("restart_wait_btn", 32'(btn_out), 32'h0);
         chk("restart_wait_busy", 32'(busy), 32'h1);
      end
      dp_in = 1'b1;
      step();
      chk("resume_busy", 32'(busy), 32'h0);

      // Randomized episodes with invalid noise in between.
      for (int e = 0; e < 40; e++) begin
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            nz = 7'($urandom_range(0, 127));
            if ($countones(~nz) == 1) nz = 7'h7F;
            seg_in = nz;
            step();
            chk("noise_btn", 32'(btn_out), 32'h0);
         end
         seg_in = 7'h7F;
         step();
         episode(int'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(R + 1, R + H + C + 3)),
                 int'($urandom_range(1, 255)), ($urandom_range(0, 7) == 0));
      end

      // Reset pulse in the middle of a press.
      chk("pre_reset_hits_nonzero", 32'(hits != 8'h00 || misses != 8'h00), 32'h1);
      seg_in = ~(7'h01 << 4);
      for (int n = 0; n <= R + 3; n++) begin
         step();
         chk("rp_btn", 32'(btn_out), 32'((n >= R + 1) ? 8'h10 : 8'h00));
         if (n == R + 1) seg_in = 7'h7F;
      end
      rst_n = 1'b0;
      step();
      m_hits   = 0;
      m_misses = 0;
      chk("rp_btn_rel", 32'(btn_out), 32'h0);
      chk("rp_busy", 32'(busy), 32'h0);
      chk_counters();
      rst_n = 1'b1;
      step();

      // Saturation: 255 hits, then one more.
      for (int i = 0; i < 255; i++) episode(i % 7, 1'b1, R + H + 1, 1, 1'b0);
      chk("hits_255", 32'(hits), 32'hFF);
      episode(3, 1'b1, R + 2, 1, 1'b0);
      chk("hits_sat", 32'(hits), 32'hFF);
      chk("misses_sat_run", 32'(misses), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
